// File: rtl/sync_pipe_sequencer.sv
// Multi-cycle instruction sequencer: walks one instruction at a time through
// FETCH, DEC, EXEC, MEM and WB, and counts retired instructions.
module sync_pipe_sequencer #(
  parameter int DEC_CYCLES  = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             fetch_en,
  output logic             dec_en,
  output logic             gpr_rd_en,
  output logic             exec_en,
  output logic             gpr_wr_en,
  output logic             pc_upd_en,
  output logic             illegal_op,
  output logic             mem_err,
  output logic             busy,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int DEC_W = $clog2(DEC_CYCLES + 1);
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DEC,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_BR,
    C_LD,
    C_ST,
    C_ALU,
    C_ILL
  } op_class_t;

  state_t     state, state_n;
  op_class_t  op_class;
  logic [DEC_W-1:0] dec_cnt;
  logic [TMO_W-1:0] wait_cnt;
  logic       dec_last;
  logic       mem_expired;
  logic       retire;

  function automatic op_class_t decode_op(input logic [6:0] op);
    op_class_t c;
    unique case (op)
      7'b1100011: c = C_BR;
      7'b0000011: c = C_LD;
      7'b0100011: c = C_ST;
      7'b0110011,
      7'b0010011,
      7'b0110111,
      7'b0010111,
      7'b1101111,
      7'b1100111: c = C_ALU;
      default:    c = C_ILL;
    endcase
    return c;
  endfunction

  assign dec_last    = (dec_cnt == DEC_W'(DEC_CYCLES - 1));
  assign mem_expired = (wait_cnt == TMO_W'(MEM_TIMEOUT - 1));
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_class   <= C_BR;
      dec_cnt    <= '0;
      wait_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == S_DEC && !dec_last)
        dec_cnt <= dec_cnt + 1'b1;
      else
        dec_cnt <= '0;
      // Wait counter only runs while MEM is held; any exit restarts it at 0.
      if (state == S_MEM && state_n == S_MEM)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (state == S_DEC && dec_last)
        op_class <= decode_op(opcode);
      if (retire)
        retire_cnt <= retire_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    fetch_en   = 1'b0;
    dec_en     = 1'b0;
    gpr_rd_en  = 1'b0;
    exec_en    = 1'b0;
    gpr_wr_en  = 1'b0;
    pc_upd_en  = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    retire     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (run)
          state_n = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        fetch_en = imem_ack;
        if (imem_ack)
          state_n = S_DEC;
      end
      S_DEC: begin
        dec_en    = 1'b1;
        gpr_rd_en = 1'b1;
        if (dec_last)
          state_n = S_EXEC;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        unique case (op_class)
          C_LD, C_ST: state_n = S_MEM;
          C_ALU:      state_n = S_WB;
          C_BR:       retire  = 1'b1;
          default: begin
            // Illegal op advances the PC but is not counted as retired.
            illegal_op = 1'b1;
            pc_upd_en  = 1'b1;
            state_n    = run ? S_FETCH : S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_class == C_ST);
        // An ack in the final wait cycle takes priority over the timeout.
        if (dmem_ack) begin
          if (op_class == C_LD)
            state_n = S_WB;
          else
            retire = 1'b1;
        end else if (mem_expired) begin
          mem_err = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WB: begin
        gpr_wr_en = 1'b1;
        retire    = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (retire) begin
      pc_upd_en = 1'b1;
      state_n   = run ? S_FETCH : S_IDLE;
    end
  end

endmodule

// File: tb/tb_sync_pipe_sequencer.sv
// Directed bench for sync_pipe_sequencer: table of single instructions plus
// hand-written reset, run-stop and counter-wrap sequences.
module tb_sync_pipe_sequencer;

  localparam int DEC_CYCLES  = 1;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             run = 1'b0;
  logic [6:0]       opcode = 7'd0;
  logic             imem_ack = 1'b0;
  logic             dmem_ack = 1'b0;
  logic             imem_req, dmem_req, dmem_we, fetch_en, dec_en, gpr_rd_en;
  logic             exec_en, gpr_wr_en, pc_upd_en, illegal_op, mem_err, busy;
  logic [CNT_W-1:0] retire_cnt;

  sync_pipe_sequencer #(
    .DEC_CYCLES (DEC_CYCLES),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .fetch_en  (fetch_en),
    .dec_en    (dec_en),
    .gpr_rd_en (gpr_rd_en),
    .exec_en   (exec_en),
    .gpr_wr_en (gpr_wr_en),
    .pc_upd_en (pc_upd_en),
    .illegal_op(illegal_op),
    .mem_err   (mem_err),
    .busy      (busy),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_cnt;

  // ilat/dlat: ack on the Nth request cycle (dlat 0 = never ack).
  typedef struct {
    logic [6:0] op;
    int ilat; int dlat;
    int cyc; int dmem; int we; int gwr; int pc; int ill; int merr; int inc;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] all_outs();
    return {imem_req, dmem_req, dmem_we, fetch_en, dec_en, gpr_rd_en,
            exec_en, gpr_wr_en, pc_upd_en, illegal_op, mem_err, busy};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, nf = 0, nd = 0, nr = 0, ne = 0, nm = 0, nw = 0;
    int ng = 0, np = 0, ni = 0, nerr = 0, bad_hot = 0, ifc = 0, dfc = 0;
    bit done = 0;
    string p;
    p = $sformatf("v%0d", idx);
    opcode = v.op;
    @(posedge clk); #1;
    run = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      run = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (imem_req) begin ifc++; imem_ack = (ifc == v.ilat); end
      if (dmem_req) begin dfc++; dmem_ack = (dfc == v.dlat); end
      #1;
      if (!busy) done = 1;
      else begin
        cyc++;
        nf   += int'(fetch_en);
        nd   += int'(dec_en);
        nr   += int'(gpr_rd_en);
        ne   += int'(exec_en);
        nm   += int'(dmem_req);
        nw   += int'(dmem_req && dmem_we);
        ng   += int'(gpr_wr_en);
        np   += int'(pc_upd_en);
        ni   += int'(illegal_op);
        nerr += int'(mem_err);
        if ($countones({imem_req, dec_en, exec_en, dmem_req, gpr_wr_en}) != 1)
          bad_hot++;
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    check({p, "_done"}, int'(done), 1);
    check({p, "_cycles"}, cyc, v.cyc);
    check({p, "_fetch_en"}, nf, 1);
    check({p, "_dec_en"}, nd, DEC_CYCLES);
    check({p, "_gpr_rd_en"}, nr, DEC_CYCLES);
    check({p, "_exec_en"}, ne, 1);
    check({p, "_dmem_req"}, nm, v.dmem);
    check({p, "_dmem_we"}, nw, v.we);
    check({p, "_gpr_wr_en"}, ng, v.gwr);
    check({p, "_pc_upd_en"}, np, v.pc);
    check({p, "_illegal_op"}, ni, v.ill);
    check({p, "_mem_err"}, nerr, v.merr);
    check({p, "_one_hot"}, bad_hot, 0);
    exp_cnt = exp_cnt + CNT_W'(v.inc);
    check({p, "_retire_cnt"}, int'(retire_cnt), int'(exp_cnt));
    check({p, "_idle_outs"}, int'(all_outs()), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    bit found;

    //            op          il dl cyc dm we gw pc il me inc
    vecs[0]  = '{7'b0110011, 1, 0, 4, 0, 0, 1, 1, 0, 0, 1};
    vecs[1]  = '{7'b0000011, 1, 3, 7, 3, 0, 1, 1, 0, 0, 1};
    vecs[2]  = '{7'b0100011, 1, 3, 6, 3, 3, 0, 1, 0, 0, 1};
    vecs[3]  = '{7'b1100011, 1, 0, 3, 0, 0, 0, 1, 0, 0, 1};
    vecs[4]  = '{7'b1111111, 1, 0, 3, 0, 0, 0, 1, 1, 0, 0};
    vecs[5]  = '{7'b0000011, 1, 0, 7, 4, 0, 0, 0, 0, 1, 0};
    vecs[6]  = '{7'b0000011, 1, 4, 8, 4, 0, 1, 1, 0, 0, 1};
    vecs[7]  = '{7'b0100011, 1, 0, 7, 4, 4, 0, 0, 0, 1, 0};
    vecs[8]  = '{7'b0100011, 1, 4, 7, 4, 4, 0, 1, 0, 0, 1};
    vecs[9]  = '{7'b0010011, 3, 0, 6, 0, 0, 1, 1, 0, 0, 1};
    vecs[10] = '{7'b0110111, 1, 0, 4, 0, 0, 1, 1, 0, 0, 1};
    vecs[11] = '{7'b0010111, 1, 0, 4, 0, 0, 1, 1, 0, 0, 1};
    vecs[12] = '{7'b1101111, 1, 0, 4, 0, 0, 1, 1, 0, 0, 1};
    vecs[13] = '{7'b1100111, 1, 0, 4, 0, 0, 1, 1, 0, 0, 1};
    vecs[14] = '{7'b0000000, 1, 0, 3, 0, 0, 0, 1, 1, 0, 0};
    vecs[15] = '{7'b1100010, 1, 0, 3, 0, 0, 0, 1, 1, 0, 0};
    vecs[16] = '{7'b0000011, 1, 1, 5, 1, 0, 1, 1, 0, 0, 1};
    vecs[17] = '{7'b0100011, 1, 1, 4, 1, 1, 0, 1, 0, 0, 1};

    // Reset held with run and ack active: nothing may start.
    reset = 1'b0;
    run = 1'b1;
    imem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", int'(all_outs()), 0);
    check("reset_retire_cnt", int'(retire_cnt), 0);
    run = 1'b0;
    imem_ack = 1'b0;
    reset = 1'b1;
    exp_cnt = '0;
    @(posedge clk); #1;
    check("idle_after_reset", int'(all_outs()), 0);

    for (int i = 0; i < NV; i++)
      run_vec(i, vecs[i]);

    // Reset while a load is waiting in MEM.
    opcode = 7'b0000011;
    @(posedge clk); #1;
    run = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      #1;
      if (dmem_req) found = 1;
    end
    check("rst_mem_reached", int'(found), 1);
    imem_ack = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mem_outs", int'(all_outs()), 0);
    check("rst_mem_retire_cnt", int'(retire_cnt), 0);
    reset = 1'b1;
    run = 1'b0;
    exp_cnt = '0;
    @(posedge clk); #1;
    check("rst_mem_idle", int'(busy), 0);

    // 16 back-to-back ALU instructions: counter wraps 15 -> 0.
    opcode = 7'b0110011;
    run = 1'b1;
    n = 0;
    cyc = 0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #1;
      if (n == 15) run = 1'b0;
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      #1;
      if (busy) cyc++;
      if (pc_upd_en) begin
        n++;
        if (n == 16) begin
          check("wrap_cnt_before", int'(retire_cnt), 15);
          found = 1;
        end
      end
    end
    imem_ack = 1'b0;
    check("wrap_reached", int'(found), 1);
    check("wrap_cycles", cyc, 64);
    @(posedge clk); #1;
    check("wrap_cnt_after", int'(retire_cnt), 0);
    check("wrap_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
